fft16_bin_streamer: RTL and testbench



---
 rtl/fft16_bin_streamer_if.sv | 35 +++
 rtl/fft16_bin_streamer.sv | 96 +++++++++
 tb/tb_fft16_bin_streamer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fft16_bin_streamer_if.sv
// Frame-in / bin-out bus of the FFT bin streamer: 16 parallel complex bins with
// valid/ready, and a one-bin-per-cycle valid/ready stream with index, last flag and frame count.
interface fft16_bin_streamer_if #(parameter int W = 16);
    logic signed [W-1:0] y0_re, y1_re, y2_re, y3_re, y4_re, y5_re, y6_re, y7_re;
    logic signed [W-1:0] y8_re, y9_re, y10_re, y11_re, y12_re, y13_re, y14_re, y15_re;
    logic signed [W-1:0] y0_im, y1_im, y2_im, y3_im, y4_im, y5_im, y6_im, y7_im;
    logic signed [W-1:0] y8_im, y9_im, y10_im, y11_im, y12_im, y13_im, y14_im, y15_im;
    logic                in_valid;
    logic                in_ready;
    logic                m_valid;
    logic                m_ready;
    logic signed [W-1:0] m_re;
    logic signed [W-1:0] m_im;
    logic [3:0]          m_idx;
    logic                m_last;
    logic [15:0]         frame_cnt;

    modport slave (
        input  y0_re, y1_re, y2_re, y3_re, y4_re, y5_re, y6_re, y7_re,
               y8_re, y9_re, y10_re, y11_re, y12_re, y13_re, y14_re, y15_re,
               y0_im, y1_im, y2_im, y3_im, y4_im, y5_im, y6_im, y7_im,
               y8_im, y9_im, y10_im, y11_im, y12_im, y13_im, y14_im, y15_im,
               in_valid, m_ready,
        output in_ready, m_valid, m_re, m_im, m_idx, m_last, frame_cnt
    );

    modport master (
        output y0_re, y1_re, y2_re, y3_re, y4_re, y5_re, y6_re, y7_re,
               y8_re, y9_re, y10_re, y11_re, y12_re, y13_re, y14_re, y15_re,
               y0_im, y1_im, y2_im, y3_im, y4_im, y5_im, y6_im, y7_im,
               y8_im, y9_im, y10_im, y11_im, y12_im, y13_im, y14_im, y15_im,
               in_valid, m_ready,
        input  in_ready, m_valid, m_re, m_im, m_idx, m_last, frame_cnt
    );
endinterface

// File: rtl/fft16_bin_streamer.sv
// Captures a 16-bin complex frame and streams it one bin per cycle (first bin the cycle after capture);
// m_ready low stalls with outputs held, and the next frame is captured on the last beat for zero-bubble frames.
module fft16_bin_streamer #(
    parameter int W      = 16,
    parameter bit BITREV = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    fft16_bin_streamer_if.slave bus
);
    typedef enum logic {IDLE, STREAM} state_t;

    state_t              state, state_nxt;
    logic [3:0]          p, p_nxt;
    logic [3:0]          idx;
    logic [15:0]         frame_cnt_r;
    logic                capture, last_xfer, in_ready_c, streaming;
    logic signed [W-1:0] in_re [16];
    logic signed [W-1:0] in_im [16];
    logic signed [W-1:0] fr_re [16];
    logic signed [W-1:0] fr_im [16];

    assign in_re[0]  = bus.y0_re;  assign in_re[1]  = bus.y1_re;  assign in_re[2]  = bus.y2_re;  assign in_re[3]  = bus.y3_re;
    assign in_re[4]  = bus.y4_re;  assign in_re[5]  = bus.y5_re;  assign in_re[6]  = bus.y6_re;  assign in_re[7]  = bus.y7_re;
    assign in_re[8]  = bus.y8_re;  assign in_re[9]  = bus.y9_re;  assign in_re[10] = bus.y10_re; assign in_re[11] = bus.y11_re;
    assign in_re[12] = bus.y12_re; assign in_re[13] = bus.y13_re; assign in_re[14] = bus.y14_re; assign in_re[15] = bus.y15_re;
    assign in_im[0]  = bus.y0_im;  assign in_im[1]  = bus.y1_im;  assign in_im[2]  = bus.y2_im;  assign in_im[3]  = bus.y3_im;
    assign in_im[4]  = bus.y4_im;  assign in_im[5]  = bus.y5_im;  assign in_im[6]  = bus.y6_im;  assign in_im[7]  = bus.y7_im;
    assign in_im[8]  = bus.y8_im;  assign in_im[9]  = bus.y9_im;  assign in_im[10] = bus.y10_im; assign in_im[11] = bus.y11_im;
    assign in_im[12] = bus.y12_im; assign in_im[13] = bus.y13_im; assign in_im[14] = bus.y14_im; assign in_im[15] = bus.y15_im;

    always_comb begin
        state_nxt  = state;
        p_nxt      = p;
        capture    = 1'b0;
        last_xfer  = 1'b0;
        in_ready_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    capture   = 1'b1;
                    p_nxt     = 4'd0;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                in_ready_c = (p == 4'd15) && bus.m_ready;
                if (bus.m_ready) begin
                    p_nxt = p + 4'd1;
                    if (p == 4'd15) begin
                        last_xfer = 1'b1;
                        // Refill on the final beat keeps the stream gap-free across frames.
                        if (bus.in_valid) begin
                            capture = 1'b1;
                            p_nxt   = 4'd0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            p           <= 4'd0;
            frame_cnt_r <= 16'd0;
        end else begin
            state <= state_nxt;
            p     <= p_nxt;
            if (last_xfer) frame_cnt_r <= frame_cnt_r + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            fr_re <= in_re;
            fr_im <= in_im;
        end
    end

    // Frame contents are don't-care after reset, so outputs are gated to zero outside STREAM.
    assign streaming     = (state == STREAM);
    assign idx           = BITREV ? {p[0], p[1], p[2], p[3]} : p;
    assign bus.m_valid   = streaming;
    assign bus.m_idx     = streaming ? idx : 4'd0;
    assign bus.m_re      = streaming ? fr_re[idx] : '0;
    assign bus.m_im      = streaming ? fr_im[idx] : '0;
    assign bus.m_last    = streaming && (p == 4'd15);
    assign bus.in_ready  = in_ready_c;
    assign bus.frame_cnt = frame_cnt_r;
endmodule

// File: tb/tb_fft16_bin_streamer.sv
// Directed bench for fft16_bin_streamer: natural and bit-reversed order, stalls, back-to-back, reset, wrap.
module tb_fft16_bin_streamer;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic signed [W-1:0] fr_re [16];
    logic signed [W-1:0] fr_im [16];
    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_cnt = 16'd0;
    int br_ord [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    fft16_bin_streamer_if #(.W(W)) bus ();
    fft16_bin_streamer_if #(.W(W)) bus_br ();

    fft16_bin_streamer #(.W(W), .BITREV(1'b0)) dut    (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    fft16_bin_streamer #(.W(W), .BITREV(1'b1)) dut_br (.clk(clk), .rst_n(rst_n), .bus(bus_br.slave));

    assign bus.y0_re  = fr_re[0];  assign bus.y1_re  = fr_re[1];  assign bus.y2_re  = fr_re[2];  assign bus.y3_re  = fr_re[3];
    assign bus.y4_re  = fr_re[4];  assign bus.y5_re  = fr_re[5];  assign bus.y6_re  = fr_re[6];  assign bus.y7_re  = fr_re[7];
    assign bus.y8_re  = fr_re[8];  assign bus.y9_re  = fr_re[9];  assign bus.y10_re = fr_re[10]; assign bus.y11_re = fr_re[11];
    assign bus.y12_re = fr_re[12]; assign bus.y13_re = fr_re[13]; assign bus.y14_re = fr_re[14]; assign bus.y15_re = fr_re[15];
    assign bus.y0_im  = fr_im[0];  assign bus.y1_im  = fr_im[1];  assign bus.y2_im  = fr_im[2];  assign bus.y3_im  = fr_im[3];
    assign bus.y4_im  = fr_im[4];  assign bus.y5_im  = fr_im[5];  assign bus.y6_im  = fr_im[6];  assign bus.y7_im  = fr_im[7];
    assign bus.y8_im  = fr_im[8];  assign bus.y9_im  = fr_im[9];  assign bus.y10_im = fr_im[10]; assign bus.y11_im = fr_im[11];
    assign bus.y12_im = fr_im[12]; assign bus.y13_im = fr_im[13]; assign bus.y14_im = fr_im[14]; assign bus.y15_im = fr_im[15];
    assign bus_br.y0_re  = fr_re[0];  assign bus_br.y1_re  = fr_re[1];  assign bus_br.y2_re  = fr_re[2];  assign bus_br.y3_re  = fr_re[3];
    assign bus_br.y4_re  = fr_re[4];  assign bus_br.y5_re  = fr_re[5];  assign bus_br.y6_re  = fr_re[6];  assign bus_br.y7_re  = fr_re[7];
    assign bus_br.y8_re  = fr_re[8];  assign bus_br.y9_re  = fr_re[9];  assign bus_br.y10_re = fr_re[10]; assign bus_br.y11_re = fr_re[11];
    assign bus_br.y12_re = fr_re[12]; assign bus_br.y13_re = fr_re[13]; assign bus_br.y14_re = fr_re[14]; assign bus_br.y15_re = fr_re[15];
    assign bus_br.y0_im  = fr_im[0];  assign bus_br.y1_im  = fr_im[1];  assign bus_br.y2_im  = fr_im[2];  assign bus_br.y3_im  = fr_im[3];
    assign bus_br.y4_im  = fr_im[4];  assign bus_br.y5_im  = fr_im[5];  assign bus_br.y6_im  = fr_im[6];  assign bus_br.y7_im  = fr_im[7];
    assign bus_br.y8_im  = fr_im[8];  assign bus_br.y9_im  = fr_im[9];  assign bus_br.y10_im = fr_im[10]; assign bus_br.y11_im = fr_im[11];
    assign bus_br.y12_im = fr_im[12]; assign bus_br.y13_im = fr_im[13]; assign bus_br.y14_im = fr_im[14]; assign bus_br.y15_im = fr_im[15];

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;    bus.m_ready = 1'b1;
        bus_br.in_valid = 1'b0; bus_br.m_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin fr_re[n] = '0; fr_im[n] = '0; end
        @(negedge clk); #1;
        n_cmp++;
        if (bus.m_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.m_last !== 1'b0) begin
            n_err++; $display("FAIL reset_ctrl: got valid=%b ready=%b last=%b want 0 1 0", bus.m_valid, bus.in_ready, bus.m_last);
        end
        n_cmp++;
        if (bus.m_re !== 16'sd0 || bus.m_im !== 16'sd0 || bus.m_idx !== 4'd0) begin
            n_err++; $display("FAIL reset_data: got re=%h im=%h idx=%0d want 0 0 0", bus.m_re, bus.m_im, bus.m_idx);
        end
        n_cmp++;
        if (bus.frame_cnt !== 16'd0) begin
            n_err++; $display("FAIL reset_cnt: got %0d want 0", bus.frame_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        for (int n = 0; n < 16; n++) begin fr_re[n] = 16'(n * 256); fr_im[n] = 16'(-n); end
        @(negedge clk); bus.in_valid = 1'b1; bus.m_ready = 1'b1; #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL basic_idle_ready: got %b want 1", bus.in_ready); end
        @(negedge clk); bus.in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            n_cmp++;
            if (bus.m_valid !== 1'b1 || bus.m_idx !== 4'(k) || bus.m_re !== fr_re[k] || bus.m_im !== fr_im[k]
                || bus.m_last !== (k == 15)) begin
                n_err++;
                $display("FAIL basic_beat%0d: got v=%b idx=%0d re=%h im=%h last=%b want v=1 idx=%0d re=%h im=%h last=%b",
                         k, bus.m_valid, bus.m_idx, bus.m_re, bus.m_im, bus.m_last, k, fr_re[k], fr_im[k], k == 15);
            end
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 16'd1;
        #1;
        n_cmp++;
        if (bus.m_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.frame_cnt !== exp_cnt) begin
            n_err++; $display("FAIL basic_end: got v=%b ready=%b cnt=%0d want 0 1 %0d", bus.m_valid, bus.in_ready, bus.frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_bitrev();
        int k;
        @(negedge clk); bus_br.in_valid = 1'b1; bus_br.m_ready = 1'b1;
        @(negedge clk); bus_br.in_valid = 1'b0;
        for (int b = 0; b < 16; b++) begin
            k = br_ord[b];
            #1;
            n_cmp++;
            if (bus_br.m_valid !== 1'b1 || bus_br.m_idx !== 4'(k) || bus_br.m_re !== fr_re[k] || bus_br.m_im !== fr_im[k]
                || bus_br.m_last !== (b == 15)) begin
                n_err++;
                $display("FAIL bitrev_beat%0d: got idx=%0d re=%h im=%h last=%b want idx=%0d re=%h im=%h last=%b",
                         b, bus_br.m_idx, bus_br.m_re, bus_br.m_im, bus_br.m_last, k, fr_re[k], fr_im[k], b == 15);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (bus_br.m_valid !== 1'b0 || bus_br.frame_cnt !== 16'd1) begin
            n_err++; $display("FAIL bitrev_end: got v=%b cnt=%0d want 0 1", bus_br.m_valid, bus_br.frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        int beat = 0;
        int cyc = 0;
        logic held_v = 1'b0;
        logic signed [W-1:0] h_re, h_im;
        logic [3:0] h_idx;
        logic h_last;
        logic rdy;
        h_re = '0; h_im = '0; h_idx = '0; h_last = 1'b0;
        for (int n = 0; n < 16; n++) begin fr_re[n] = 16'(16'h0300 + n); fr_im[n] = 16'(~n); end
        @(negedge clk); bus.in_valid = 1'b1; bus.m_ready = 1'b1;
        @(negedge clk); bus.in_valid = 1'b0;
        while (beat < 16 && cyc < 100) begin
            rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            bus.m_ready = rdy;
            #1;
            if (held_v) begin
                n_cmp++;
                if (bus.m_re !== h_re || bus.m_im !== h_im || bus.m_idx !== h_idx || bus.m_last !== h_last) begin
                    n_err++; $display("FAIL bp_stall_hold cyc%0d: got idx=%0d re=%h want idx=%0d re=%h", cyc, bus.m_idx, bus.m_re, h_idx, h_re);
                end
            end
            n_cmp++;
            if (bus.m_valid !== 1'b1 || bus.m_idx !== 4'(beat) || bus.m_re !== fr_re[beat] || bus.m_im !== fr_im[beat]) begin
                n_err++; $display("FAIL bp_beat%0d: got v=%b idx=%0d re=%h im=%h want v=1 idx=%0d re=%h im=%h",
                                  beat, bus.m_valid, bus.m_idx, bus.m_re, bus.m_im, beat, fr_re[beat], fr_im[beat]);
            end
            h_re = bus.m_re; h_im = bus.m_im; h_idx = bus.m_idx; h_last = bus.m_last;
            held_v = !rdy;
            if (rdy) beat++;
            cyc++;
            @(negedge clk);
        end
        bus.m_ready = 1'b1;
        exp_cnt = exp_cnt + 16'd1;
        #1;
        n_cmp++;
        if (beat != 16 || bus.m_valid !== 1'b0 || bus.frame_cnt !== exp_cnt) begin
            n_err++; $display("FAIL bp_end: got beats=%0d v=%b cnt=%0d want 16 0 %0d", beat, bus.m_valid, bus.frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [W-1:0] e_re;
        for (int n = 0; n < 16; n++) begin fr_re[n] = 16'(16'h1000 + n); fr_im[n] = 16'(16'h1000 + n); end
        @(negedge clk); bus.in_valid = 1'b1; bus.m_ready = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 16; n++) begin fr_re[n] = 16'(16'h2000 + n); fr_im[n] = 16'(16'h2000 + n); end
        for (int k = 0; k < 32; k++) begin
            if (k == 16) bus.in_valid = 1'b0;
            e_re = (k < 16) ? 16'(16'h1000 + k) : 16'(16'h2000 + k - 16);
            #1;
            n_cmp++;
            if (bus.m_valid !== 1'b1 || bus.m_idx !== 4'(k % 16) || bus.m_re !== e_re || bus.m_im !== e_re
                || bus.m_last !== (k % 16 == 15)) begin
                n_err++; $display("FAIL b2b_beat%0d: got v=%b idx=%0d re=%h im=%h want v=1 idx=%0d re/im=%h",
                                  k, bus.m_valid, bus.m_idx, bus.m_re, bus.m_im, k % 16, e_re);
            end
            if (k == 15 || k == 14) begin
                n_cmp++;
                if (bus.in_ready !== (k == 15)) begin
                    n_err++; $display("FAIL b2b_in_ready%0d: got %b want %b", k, bus.in_ready, k == 15);
                end
            end
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 16'd2;
        #1;
        n_cmp++;
        if (bus.m_valid !== 1'b0 || bus.frame_cnt !== exp_cnt) begin
            n_err++; $display("FAIL b2b_end: got v=%b cnt=%0d want 0 %0d", bus.m_valid, bus.frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int n = 0; n < 16; n++) begin fr_re[n] = 16'(16'h0500 + n); fr_im[n] = 16'(16'h0600 + n); end
        @(negedge clk); bus.in_valid = 1'b1; bus.m_ready = 1'b1;
        @(negedge clk); bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.m_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.frame_cnt !== 16'd0) begin
            n_err++; $display("FAIL midreset_async: got v=%b ready=%b cnt=%0d want 0 1 0", bus.m_valid, bus.in_ready, bus.frame_cnt);
        end
        exp_cnt = 16'd0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); bus.in_valid = 1'b1;
        @(negedge clk); bus.in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            n_cmp++;
            if (bus.m_valid !== 1'b1 || bus.m_idx !== 4'(k) || bus.m_re !== fr_re[k]) begin
                n_err++; $display("FAIL midreset_beat%0d: got v=%b idx=%0d re=%h want v=1 idx=%0d re=%h",
                                  k, bus.m_valid, bus.m_idx, bus.m_re, k, fr_re[k]);
            end
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 16'd1;
        #1;
        n_cmp++;
        if (bus.frame_cnt !== exp_cnt) begin
            n_err++; $display("FAIL midreset_cnt: got %0d want %0d", bus.frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_wrap_passthrough();
        for (int n = 0; n < 16; n++) begin
            fr_re[n] = (n % 2 == 0) ? 16'h8000 : 16'h7FFF;
            fr_im[n] = (n % 2 == 0) ? 16'h7FFF : 16'h8000;
        end
        @(negedge clk);
        dut.frame_cnt_r = 16'hFFFF;
        #1;
        n_cmp++;
        if (bus.frame_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload: got %h want ffff", bus.frame_cnt); end
        @(negedge clk); bus.in_valid = 1'b1; bus.m_ready = 1'b1;
        @(negedge clk); bus.in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            n_cmp++;
            if (bus.m_re !== fr_re[k] || bus.m_im !== fr_im[k] || bus.m_idx !== 4'(k)) begin
                n_err++; $display("FAIL wrap_beat%0d: got idx=%0d re=%h im=%h want idx=%0d re=%h im=%h",
                                  k, bus.m_idx, bus.m_re, bus.m_im, k, fr_re[k], fr_im[k]);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (bus.frame_cnt !== 16'h0000 || bus.m_valid !== 1'b0) begin
            n_err++; $display("FAIL wrap_cnt: got cnt=%h v=%b want 0000 0", bus.frame_cnt, bus.m_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bitrev();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_wrap_passthrough();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
